// File: rtl/float_point_divide.sv
// IEEE-754 single-precision divider, iterative restoring mantissa core.
// One quotient bit per cycle; fixed 30-edge start-to-done latency.
module float_point_divide (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iValid,
  output logic        oDone,
  output logic [31:0] oZ
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIVIDE,
    ROUND,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0] a_q, b_q;
  logic        sign_q;
  logic [9:0]  exp_q;
  logic [24:0] rem_q, rem_d;
  logic [23:0] div_q;
  logic [26:0] quo_q, quo_d;
  logic [4:0]  cnt_q;
  logic        spec_q, spec_d;
  logic [31:0] spec_z_q, spec_z_d;
  logic [31:0] res_q, res_d;
  logic [31:0] z_q;
  logic        done_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sgn;
  logic        a_nan, b_nan;
  logic        a_inf, b_inf;
  logic        a_zero, b_zero;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign sgn    = a_q[31] ^ b_q[31];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  // Denormals have a zero exponent and are flushed to zero here.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  always_comb begin
    spec_d   = 1'b1;
    spec_z_d = {sgn, 31'd0};
    if (a_nan || b_nan) begin
      spec_z_d = 32'h7FC0_0000;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_z_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      spec_z_d = {sgn, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_z_d = {sgn, 31'd0};
    end else if (b_zero) begin
      spec_z_d = {sgn, 8'hFF, 23'd0};
    end else if (a_zero) begin
      spec_z_d = {sgn, 31'd0};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic        ge;
  logic [24:0] diff;

  always_comb begin
    ge    = rem_q >= {1'b0, div_q};
    diff  = ge ? rem_q - {1'b0, div_q} : rem_q;
    rem_d = diff << 1;
    quo_d = {quo_q[25:0], ge};
  end

  logic        norm;
  logic [23:0] man;
  logic        grd, stk, up;
  logic [24:0] sum;
  logic [22:0] frac_r;
  logic [9:0]  e1, e2;
  logic        ovf, unf;

  always_comb begin
    norm   = quo_q[26];
    man    = norm ? quo_q[26:3] : quo_q[25:2];
    grd    = norm ? quo_q[2] : quo_q[1];
    stk    = (norm ? |quo_q[1:0] : quo_q[0])
           | (rem_q != 25'd0);
    e1     = norm ? exp_q : exp_q - 10'd1;
    up     = grd & (stk | man[0]);
    sum    = {1'b0, man} + {24'd0, up};
    frac_r = sum[24] ? sum[23:1] : sum[22:0];
    e2     = sum[24] ? e1 + 10'd1 : e1;
    ovf    = !e2[9] && (e2[8:0] >= 9'd255);
    unf    = e2[9] || (e2 == 10'd0);
    res_d  = {sign_q, e2[7:0], frac_r};
    if (spec_q) begin
      res_d = spec_z_q;
    end else if (ovf) begin
      res_d = {sign_q, 8'hFF, 23'd0};
    end else if (unf) begin
      res_d = {sign_q, 31'd0};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iValid) state_d = PREP;
      PREP:    state_d = DIVIDE;
      DIVIDE:  if (cnt_q == 5'd0) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      spec_q   <= 1'b0;
      spec_z_q <= '0;
      res_q    <= '0;
      z_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iValid) begin
            a_q <= iA;
            b_q <= iB;
          end
        end
        PREP: begin
          sign_q   <= sgn;
          exp_q    <= {2'b0, ea} - {2'b0, eb} + 10'd127;
          rem_q    <= {2'b01, fa};
          div_q    <= {1'b1, fb};
          quo_q    <= '0;
          cnt_q    <= 5'd26;
          spec_q   <= spec_d;
          spec_z_q <= spec_z_d;
        end
        DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 5'd1;
        end
        ROUND: begin
          res_q <= res_d;
        end
        DONE: begin
          z_q    <= res_q;
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign oDone = done_q;
  assign oZ    = z_q;

endmodule

// File: tb/tb_float_point_divide.sv
// Scoreboard bench for float_point_divide: directed vectors,
// latency, ignored-request and mid-operation reset checks.
module tb_float_point_divide;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        iValid = 1'b0;
  logic        oDone;
  logic [31:0] oZ;

  float_point_divide dut (
    .clk    (clk),
    .resetn (resetn),
    .iA     (iA),
    .iB     (iB),
    .iValid (iValid),
    .oDone  (oDone),
    .oZ     (oZ)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  int dones  = 0;
  int n_exp  = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];
  logic [31:0] mon_e;
  int          mon_d;

  always @(negedge clk) begin
    if (resetn && oDone) begin
      dones++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done oZ=%h required no oDone", oZ);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = due_q.pop_front();
        if (oZ !== mon_e) begin
          fails++;
          $display("FAIL result oZ=%h required %h", oZ, mon_e);
        end
        checks++;
        if (cyc != mon_d) begin
          fails++;
          $display("FAIL latency done_edge=%0d required %0d",
                   cyc, mon_d);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h required %h", nm, got, want);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z);
    @(negedge clk);
    iA     = a;
    iB     = b;
    iValid = 1'b1;
    exp_q.push_back(z);
    due_q.push_back(cyc + 1 + 30);
    n_exp++;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout pending=%0d required 0", exp_q.size());
      n_exp = n_exp - exp_q.size();
      exp_q.delete();
      due_q.delete();
    end
  endtask

  logic [31:0] va[10] = '{
    32'h3FC00000, 32'hC3D48000, 32'h3F800000, 32'h40000000,
    32'h40000000, 32'hC0000000, 32'h00000000, 32'h7FC00001,
    32'h7F000000, 32'h00800000
  };
  logic [31:0] vb[10] = '{
    32'h3F000000, 32'h41080000, 32'h40400000, 32'h3F800000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000,
    32'h3E800000, 32'h40000000
  };
  logic [31:0] vz[10] = '{
    32'h40400000, 32'hC2480000, 32'h3EAAAAAB, 32'h40000000,
    32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
    32'h7F800000, 32'h00000000
  };

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_done", {31'd0, oDone}, 32'd0);
    chk("reset_z", oZ, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    issue(32'h7F800000, 32'h7E000000, 32'h7F800000);
    wait_done();
    @(negedge clk);
    chk("done_low", {31'd0, oDone}, 32'd0);
    chk("z_hold", oZ, 32'h7F800000);
    repeat (3) @(negedge clk);
    chk("z_hold2", oZ, 32'h7F800000);

    for (int i = 0; i < 10; i++) begin
      issue(va[i], vb[i], vz[i]);
      wait_done();
    end

    issue(32'h3FC00000, 32'h3F000000, 32'h40400000);
    repeat (10) @(negedge clk);
    iA     = 32'h3F800000;
    iB     = 32'h40400000;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_done", {31'd0, oDone}, 32'd0);
    chk("abort_z", oZ, 32'd0);
    n_exp = n_exp - exp_q.size();
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_z", oZ, 32'd0);

    issue(32'h40000000, 32'h3F800000, 32'h40000000);
    wait_done();
    chk("done_count", dones, n_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
